game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//   Top-level game sequencer for the stickman-run display. Owns the 4-bit
//   one-hot status bus {waiting, playing, win, lose} consumed by
//   color_mapper, and keeps score and remaining time.
//   Issues a one-cycle round-restart pulse to the stickman, ground and coin
//   logic, and a play-enable level.
//   Advances timers on the VGA frame boundary (vs rising edge).
// PARAMETERS
//   WIN_SCORE    10    coins needed to win; 1..2^SCORE_W-1
//   TIME_FRAMES  3600  frames per round (60 s at 60 Hz)
//   HOLD_FRAMES  180   frames the win/lose screen is held before returning
//   SCORE_W      8     score counter width
//   TIMER_W      12    time_left width; TIME_FRAMES, HOLD_FRAMES < 2^TIMER_W
// PORTS
//   Clk         in   1        system clock, 50 MHz
//   Reset_n     in   1        async active-low reset
//   frame_clk   in   1        VGA vs, synchronous to Clk; rising edge = frame tick
//   start_key   in   1        level; start key held (decoded keycode)
//   coin_hit    in   1        level from coin logic; each rising edge = +1 coin
//   collision   in   1        level; stickman hit an obstacle or fell
//   status      out  4        one-hot {waiting,playing,win,lose} to color_mapper
//   play_en     out  1        1 only in PLAY; gates stickman/ground motion
//   round_rst   out  1        1-cycle pulse on WAIT->PLAY
//   score       out  SCORE_W  coins this round
//   time_left   out  TIMER_W  frames remaining in round
// BEHAVIOUR
//   - All outputs registered; status is decoded from the state register (no glitches).
//   - Reset (async, any time, including mid-round): state PREWAIT,
//     status=4'b1000, play_en=0, round_rst=0, score=0, time_left=TIME_FRAMES,
//     hold counter=0, edge-detect registers=0.
//   - Edge detect: tick = frame_clk & ~frame_clk_q; coin = coin_hit & ~coin_hit_q.
//     One-cycle pulses; a held coin_hit counts once.
//   - States and status: PREWAIT->1000, WAIT->1000, PLAY->0100, WIN->0010,
//     LOSE->0001.
//   - PREWAIT: go to WAIT when start_key==0. This ensures a key held from the
//     previous round cannot auto-start the next one.
//   - WAIT: start_key==1 -> PLAY next cycle. On the same edge: round_rst=1 for
//     one cycle, score<=0, time_left<=TIME_FRAMES.
//   - PLAY, evaluated each cycle, priority high to low:
//     1. collision==1 -> LOSE.
//     2. coin && score==WIN_SCORE-1 -> score<=WIN_SCORE, WIN.
//     3. tick && time_left==1 -> time_left<=0, LOSE.
//     4. Otherwise, coin -> score+1 and tick -> time_left-1, independently.
//   - On the PLAY->LOSE or PLAY->WIN edge, score and time_left are not updated
//     except as stated in 2/3. A collision in the same cycle as a winning coin
//     yields LOSE, with score unchanged.
//   - WIN/LOSE: play_en=0; score and time_left frozen for display.
//     The hold counter clears on entry and increments on each tick.
//     When it reaches HOLD_FRAMES -> PREWAIT.
//     start_key, coin and collision are ignored in these states.
//   - score never exceeds WIN_SCORE and time_left never decrements below 0;
//     no wrap-around.
//   - play_en=1 exactly while in PLAY (registered with state).
//   - Unused encodings recover to PREWAIT.
// STRUCTURE
//   - game_pkg: state enum {PREWAIT,WAIT,PLAY,WIN,LOSE}; status constants
//     ST_WAITING=4'b1000, ST_PLAYING=4'b0100, ST_WIN=4'b0010, ST_LOSE=4'b0001.
//     The package is shared with color_mapper.
//   - Sub-module rise_pulse (1-bit registered rising-edge detector, async
//     active-low reset): two instances, one for frame_clk and one for coin_hit.
//   - Remaining FSM and counters stay inline.
// TESTING
//   1. Reset with start_key=1 held -> status=1000, score=0, time_left=3600.
//      State stays PREWAIT until start_key=0; round_rst stays 0.
//   2. start_key 0->1 in WAIT -> next cycle status=0100, play_en=1, one
//      round_rst pulse. Then 5 frame ticks -> time_left=3595.
//   3. Ten coin_hit rising edges in PLAY, one held 20 cycles -> score 1..10.
//      After the 10th: status=0010, play_en=0, score stays 10.
//   4. collision and the 10th coin edge in the same cycle -> status=0001,
//      score=9.
//   5. TIME_FRAMES=4, no coins -> after 4 ticks time_left=0, status=0001.
//      After HOLD_FRAMES ticks -> status=1000, state PREWAIT.
//   6. Reset_n pulsed low mid-PLAY, asynchronously between edges -> outputs
//      return immediately to reset values; no round_rst pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-state definitions: sequencer states and the one-hot status codes
// that color_mapper decodes.
package game_pkg;

    typedef enum logic [2:0] {
        PREWAIT = 3'd0,
        WAIT    = 3'd1,
        PLAY    = 3'd2,
        WIN     = 3'd3,
        LOSE    = 3'd4
    } game_state_t;

    localparam logic [3:0] ST_WAITING = 4'b1000;
    localparam logic [3:0] ST_PLAYING = 4'b0100;
    localparam logic [3:0] ST_WIN     = 4'b0010;
    localparam logic [3:0] ST_LOSE    = 4'b0001;

    function automatic logic [3:0] status_of(input game_state_t s);
        logic [3:0] st;
        st = ST_WAITING;
        case (s)
            PLAY:    st = ST_PLAYING;
            WIN:     st = ST_WIN;
            LOSE:    st = ST_LOSE;
            default: st = ST_WAITING;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rise_pulse.sv
// One-cycle pulse on each rising edge of a level that is synchronous to clk.
module rise_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: waiting/playing/win/lose screens, score and round timer,
// all advanced on VGA frame ticks and coin edges.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 10,
    parameter int unsigned TIME_FRAMES = 3600,
    parameter int unsigned HOLD_FRAMES = 180,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned TIMER_W     = 12
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               start_key,
    input  logic               coin_hit,
    input  logic               collision,
    output logic [3:0]         status,
    output logic               play_en,
    output logic               round_rst,
    output logic [SCORE_W-1:0] score,
    output logic [TIMER_W-1:0] time_left
);

    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(WIN_SCORE - 1);
    localparam logic [TIMER_W-1:0] TIME_FULL  = TIMER_W'(TIME_FRAMES);
    localparam logic [TIMER_W-1:0] HOLD_END   = TIMER_W'(HOLD_FRAMES);

    logic tick;
    logic coin;

    rise_pulse u_frame_edge (
        .clk   (Clk),
        .rst_n (Reset_n),
        .din   (frame_clk),
        .pulse (tick)
    );

    rise_pulse u_coin_edge (
        .clk   (Clk),
        .rst_n (Reset_n),
        .din   (coin_hit),
        .pulse (coin)
    );

    game_state_t        state_reg, state_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [TIMER_W-1:0] time_reg, time_next;
    logic [TIMER_W-1:0] hold_reg, hold_next;
    logic [TIMER_W-1:0] hold_inc;
    logic               round_rst_reg, round_rst_next;
    logic [3:0]         status_reg;
    logic               play_en_reg;

    assign hold_inc = hold_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        score_next     = score_reg;
        time_next      = time_reg;
        hold_next      = hold_reg;
        round_rst_next = 1'b0;

        case (state_reg)
            PREWAIT: begin
                // Wait for key release so a held key cannot auto-start a round.
                if (!start_key) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (start_key) begin
                    state_next     = PLAY;
                    round_rst_next = 1'b1;
                    score_next     = '0;
                    time_next      = TIME_FULL;
                end
            end
            PLAY: begin
                if (collision) begin
                    state_next = LOSE;
                    hold_next  = '0;
                end else if (coin && score_reg == SCORE_LAST) begin
                    score_next = SCORE_WIN;
                    state_next = WIN;
                    hold_next  = '0;
                end else if (tick && time_reg == TIMER_W'(1)) begin
                    time_next  = '0;
                    state_next = LOSE;
                    hold_next  = '0;
                end else begin
                    if (coin && score_reg < SCORE_WIN) begin
                        score_next = score_reg + 1'b1;
                    end
                    if (tick && time_reg != '0) begin
                        time_next = time_reg - 1'b1;
                    end
                end
            end
            WIN, LOSE: begin
                // Score and timer stay frozen for display; only frame ticks matter.
                if (tick) begin
                    if (hold_inc == HOLD_END) begin
                        state_next = PREWAIT;
                    end else begin
                        hold_next = hold_inc;
                    end
                end
            end
            default: begin
                state_next = PREWAIT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= PREWAIT;
            score_reg     <= '0;
            time_reg      <= TIME_FULL;
            hold_reg      <= '0;
            round_rst_reg <= 1'b0;
            status_reg    <= ST_WAITING;
            play_en_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            score_reg     <= score_next;
            time_reg      <= time_next;
            hold_reg      <= hold_next;
            round_rst_reg <= round_rst_next;
            status_reg    <= status_of(state_next);
            play_en_reg   <= (state_next == PLAY);
        end
    end

    assign status    = status_reg;
    assign play_en   = play_en_reg;
    assign round_rst = round_rst_reg;
    assign score     = score_reg;
    assign time_left = time_reg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed round scenarios plus random play, all
// compared each cycle against a rule-level model of the game.
module tb_game_state_ctrl;

    localparam int WS = 10;
    localparam int TF = 3600;
    localparam int HF = 180;

    localparam int M_LOCKED = 0;
    localparam int M_READY  = 1;
    localparam int M_RUN    = 2;
    localparam int M_WON    = 3;
    localparam int M_LOST   = 4;

    logic        Clk;
    logic        Reset_n;
    logic        frame_clk;
    logic        start_key;
    logic        coin_hit;
    logic        collision;
    logic [3:0]  status;
    logic        play_en;
    logic        round_rst;
    logic [7:0]  score;
    logic [11:0] time_left;

    int tests = 0;
    int fails = 0;

    game_state_ctrl #(
        .WIN_SCORE   (WS),
        .TIME_FRAMES (TF),
        .HOLD_FRAMES (HF),
        .SCORE_W     (8),
        .TIMER_W     (12)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .start_key (start_key),
        .coin_hit  (coin_hit),
        .collision (collision),
        .status    (status),
        .play_en   (play_en),
        .round_rst (round_rst),
        .score     (score),
        .time_left (time_left)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        int mode;
        int sc;
        int tl;
        int hc;
        bit pf;
        bit pc;
        bit rr;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_reset();
        mdl_t r;
        r.mode = M_LOCKED; r.sc = 0; r.tl = TF; r.hc = 0;
        r.pf = 1'b0; r.pc = 1'b0; r.rr = 1'b0;
        return r;
    endfunction

    // One clock of game rules applied to the sampled inputs.
    function automatic mdl_t model_step(mdl_t cur, bit fr, bit ch, bit sk, bit col);
        mdl_t n;
        bit tk;
        bit cn;
        n = cur;
        tk = fr && !cur.pf;
        cn = ch && !cur.pc;
        n.pf = fr;
        n.pc = ch;
        n.rr = 1'b0;
        if (cur.mode == M_LOCKED) begin
            if (!sk) n.mode = M_READY;
        end else if (cur.mode == M_READY) begin
            if (sk) begin
                n.mode = M_RUN; n.rr = 1'b1; n.sc = 0; n.tl = TF;
            end
        end else if (cur.mode == M_RUN) begin
            if (col) begin
                n.mode = M_LOST; n.hc = 0;
            end else if (cn && cur.sc + 1 == WS) begin
                n.sc = WS; n.mode = M_WON; n.hc = 0;
            end else if (tk && cur.tl == 1) begin
                n.tl = 0; n.mode = M_LOST; n.hc = 0;
            end else begin
                if (cn) n.sc = cur.sc + 1;
                if (tk) n.tl = cur.tl - 1;
            end
        end else begin
            if (tk) begin
                n.hc = cur.hc + 1;
                if (n.hc == HF) n.mode = M_LOCKED;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_status(int mode);
        if (mode == M_RUN)  return 4'b0100;
        if (mode == M_WON)  return 4'b0010;
        if (mode == M_LOST) return 4'b0001;
        return 4'b1000;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m <= model_reset();
        else          m <= model_step(m, frame_clk, coin_hit, start_key, collision);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        check("status",    {28'd0, status},     {28'd0, exp_status(m.mode)});
        check("play_en",   {31'd0, play_en},    {31'd0, (m.mode == M_RUN)});
        check("round_rst", {31'd0, round_rst},  {31'd0, m.rr});
        check("score",     {24'd0, score},      m.sc);
        check("time_left", {20'd0, time_left},  m.tl);
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1; step();
        frame_clk = 1'b0; step();
    endtask

    task automatic coin_pulse(input int hold);
        coin_hit = 1'b1;
        repeat (hold) step();
        coin_hit = 1'b0;
        step();
    endtask

    task automatic start_round();
        start_key = 1'b0; step(); step();
        start_key = 1'b1; step();
        check("start_status",    {28'd0, status}, 32'b0100);
        check("start_play_en",   {31'd0, play_en}, 32'd1);
        check("start_round_rst", {31'd0, round_rst}, 32'd1);
        start_key = 1'b0; step();
        check("round_rst_once",  {31'd0, round_rst}, 32'd0);
    endtask

    task automatic hold_out(input logic [3:0] screen);
        repeat (HF - 1) frame_tick();
        check("hold_not_done", {28'd0, status}, {28'd0, screen});
        frame_tick();
        check("hold_done", {28'd0, status}, 32'b1000);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n = 1'b0; start_key = 1'b1; frame_clk = 1'b0;
        coin_hit = 1'b0; collision = 1'b0;
        repeat (3) step();
        check("rst_status", {28'd0, status}, 32'b1000);
        check("rst_score",  {24'd0, score}, 32'd0);
        check("rst_time",   {20'd0, time_left}, 32'd3600);
        Reset_n = 1'b1;
        repeat (5) step();
        check("held_key_status", {28'd0, status}, 32'b1000);
        check("held_key_rr",     {31'd0, round_rst}, 32'd0);

        // Round 1: timer ticks then a win
        start_round();
        repeat (5) frame_tick();
        check("time_after_5", {20'd0, time_left}, 32'd3595);
        for (int i = 1; i <= WS; i++) begin
            coin_pulse((i == 3) ? 20 : 1);
            check("score_count", {24'd0, score}, i);
        end
        check("win_status",  {28'd0, status}, 32'b0010);
        check("win_play_en", {31'd0, play_en}, 32'd0);
        coin_pulse(1);
        collision = 1'b1; step(); collision = 1'b0; step();
        check("win_frozen_score", {24'd0, score}, 32'd10);
        check("win_ignores_col",  {28'd0, status}, 32'b0010);
        hold_out(4'b0010);

        // Round 2: collision with the winning coin
        start_round();
        repeat (WS - 1) coin_pulse(1);
        coin_hit = 1'b1; collision = 1'b1; step();
        coin_hit = 1'b0; collision = 1'b0; step();
        check("col_win_status", {28'd0, status}, 32'b0001);
        check("col_win_score",  {24'd0, score}, 32'd9);
        check("col_win_time",   {20'd0, time_left}, 32'd3600);
        hold_out(4'b0001);

        // Round 3: timeout
        start_round();
        repeat (TF - 1) frame_tick();
        check("time_one",      {20'd0, time_left}, 32'd1);
        check("time_one_play", {28'd0, status}, 32'b0100);
        frame_tick();
        check("time_zero",      {20'd0, time_left}, 32'd0);
        check("timeout_status", {28'd0, status}, 32'b0001);
        hold_out(4'b0001);

        // Round 4: async reset mid-play
        start_round();
        repeat (3) frame_tick();
        coin_pulse(1);
        start_key = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        check("async_status",  {28'd0, status}, 32'b1000);
        check("async_play_en", {31'd0, play_en}, 32'd0);
        check("async_score",   {24'd0, score}, 32'd0);
        check("async_time",    {20'd0, time_left}, 32'd3600);
        check("async_rr",      {31'd0, round_rst}, 32'd0);
        step();
        Reset_n = 1'b1;
        repeat (4) begin
            step();
            check("post_rst_rr", {31'd0, round_rst}, 32'd0);
        end
        check("post_rst_status", {28'd0, status}, 32'b1000);

        // Random play, checked by the per-cycle model comparison
        start_key = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 3) == 0) coin_hit = ~coin_hit;
            if ($urandom_range(0, 15) == 0) start_key = ~start_key;
            collision = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
